// File: rtl/text_overlay_gen.sv
// text_overlay_gen: text-mode overlay with writable character buffer, blinking cursor
// and clear sweep; 3-cycle pixel latency from x/y/video_on to r/g/b.
module text_overlay_gen #(
  parameter int          CHAR_W       = 8,
  parameter int          CHAR_H       = 8,
  parameter int          COLS         = 80,
  parameter int          ROWS         = 60,
  parameter logic [23:0] FG_COLOR     = 24'hFFFFFF,
  parameter logic [23:0] BG_COLOR     = 24'h000000,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [7:0]  CLEAR_CHAR   = 8'h20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       video_on,
  input  logic       wr_en,
  input  logic [6:0] wr_col,
  input  logic [5:0] wr_row,
  input  logic [7:0] wr_char,
  output logic       wr_ready,
  input  logic       clear_req,
  input  logic       cursor_en,
  input  logic [6:0] cur_col,
  input  logic [5:0] cur_row,
  output logic [7:0] glyph_char,
  output logic [3:0] glyph_row,
  input  logic [7:0] glyph_bits,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b
);
  localparam int N  = COLS * ROWS;
  localparam int AW = $clog2(N);
  localparam int CW = $clog2(CHAR_W);
  localparam int CH = $clog2(CHAR_H);
  localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t          state;
  logic [AW-1:0]   clr_addr, rd_addr, wr_addr, mem_addr;
  logic [7:0]      mem [N];
  logic [7:0]      mem_data;
  logic            mem_we, usr_we, tick, in_area, is_cur, pix, blink_last;
  int              col, row;
  logic [CW-1:0]   fx, s1_fx, s2_fx;
  logic            s1_in, s2_in, s1_cur, s2_cur, blink_phase;
  logic [BW-1:0]   blink_cnt;
  always_comb begin
    col        = int'(x >> CW);
    row        = int'(y >> CH);
    fx         = x[CW-1:0];
    in_area    = video_on && col < COLS && row < ROWS;
    is_cur     = cursor_en && col == int'(cur_col) && row == int'(cur_row);
    rd_addr    = AW'(row * COLS + col);
    tick       = x == '0 && y == '0;
    blink_last = blink_cnt == BW'(BLINK_FRAMES - 1);
    usr_we     = wr_en && wr_ready && !clear_req && int'(wr_col) < COLS && int'(wr_row) < ROWS;
    wr_addr    = AW'(int'(wr_row) * COLS + int'(wr_col));
    mem_we     = state == CLEAR || usr_we;
    mem_addr   = state == CLEAR ? clr_addr : wr_addr;
    mem_data   = state == CLEAR ? CLEAR_CHAR : wr_char;
    pix        = glyph_bits[3'(CHAR_W - 1 - int'(s2_fx))] ^ (s2_cur && blink_phase);
  end
  // A clear request restarts the sweep from cell 0 in either state.
  always_ff @(posedge clk) begin
    if (rst || clear_req) begin
      state    <= CLEAR;
      clr_addr <= '0;
      wr_ready <= 1'b0;
    end else if (state == CLEAR) begin
      clr_addr <= clr_addr + AW'(1);
      if (clr_addr == AW'(N - 1)) begin
        state    <= IDLE;
        wr_ready <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_data;
  end
  // glyph_char is the buffer's synchronous read register; collisions return old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      glyph_char  <= '0;
      glyph_row   <= '0;
      s1_fx       <= '0;
      s2_fx       <= '0;
      s1_in       <= 1'b0;
      s2_in       <= 1'b0;
      s1_cur      <= 1'b0;
      s2_cur      <= 1'b0;
      {r, g, b}   <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else begin
      glyph_char <= mem[rd_addr];
      glyph_row  <= 4'(y[CH-1:0]);
      s1_fx      <= fx;
      s1_in      <= in_area;
      s1_cur     <= is_cur;
      s2_fx      <= s1_fx;
      s2_in      <= s1_in;
      s2_cur     <= s1_cur;
      {r, g, b}  <= s2_in ? (pix ? FG_COLOR : BG_COLOR) : 24'h000000;
      if (tick) begin
        blink_cnt   <= blink_last ? '0 : blink_cnt + BW'(1);
        blink_phase <= blink_last ? !blink_phase : blink_phase;
      end
    end
  end
endmodule

// File: tb/tb_text_overlay_gen.sv
// tb_text_overlay_gen: directed scoreboard bench for text_overlay_gen with a model glyph ROM.
module tb_text_overlay_gen;
  localparam int COLS = 80, ROWS = 60, N = COLS * ROWS, BF = 2;
  logic       clk = 0, rst = 1;
  logic [9:0] x = 10'd700, y = 10'd500;
  logic       video_on = 0, wr_en = 0, clear_req = 0, cursor_en = 0;
  logic [6:0] wr_col = 0, cur_col = 0;
  logic [5:0] wr_row = 0, cur_row = 0;
  logic [7:0] wr_char = 0, glyph_char, glyph_bits = 0, r, g, b;
  logic [3:0] glyph_row;
  logic       wr_ready;
  text_overlay_gen #(.BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .video_on(video_on),
    .wr_en(wr_en), .wr_col(wr_col), .wr_row(wr_row), .wr_char(wr_char), .wr_ready(wr_ready),
    .clear_req(clear_req), .cursor_en(cursor_en), .cur_col(cur_col), .cur_row(cur_row),
    .glyph_char(glyph_char), .glyph_row(glyph_row), .glyph_bits(glyph_bits),
    .r(r), .g(g), .b(b)
  );
  always #5 clk = ~clk;
  typedef struct {int due; logic [31:0] v;} item_t;
  item_t      qc[$], qp[$];
  logic [7:0] mdl [N];
  int         cyc = 0, nt = 0, n_assert = 0, n_fail = 0;
  bit         idle = 0;
  always @(posedge clk) cyc++;
  function automatic logic [7:0] rom(input logic [7:0] c, input logic [3:0] rw);
    if (c == 8'h20) return 8'h00;
    if (c != 8'h41) return c ^ {rw, rw};
    case (rw[2:0])
      3'd0: return 8'h18;
      3'd1: return 8'h24;
      3'd2, 3'd3, 3'd5, 3'd6: return 8'h42;
      3'd4: return 8'h7E;
      default: return 8'h00;
    endcase
  endfunction
  always @(posedge clk) glyph_bits <= rom(glyph_char, glyph_row);
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    while (qc.size() > 0 && qc[0].due <= cyc) begin
      item_t it;
      it = qc.pop_front();
      chk("glyph", {20'b0, glyph_row, glyph_char}, it.v);
    end
    while (qp.size() > 0 && qp[0].due <= cyc) begin
      item_t it;
      it = qp.pop_front();
      chk("rgb", {8'b0, r, g, b}, it.v);
    end
  end
  function automatic logic [23:0] exp_rgb(input int xx, input int yy, input bit von);
    int c, rr;
    logic [7:0] bits;
    logic p;
    c = xx / 8;
    rr = yy / 8;
    if (!von || c >= COLS || rr >= ROWS) return 24'h0;
    bits = rom(mdl[rr * COLS + c], 4'(yy % 8));
    p = bits[7 - xx % 8];
    if (cursor_en && c == int'(cur_col) && rr == int'(cur_row) && (nt / BF) % 2 == 0) p = !p;
    return p ? 24'hFFFFFF : 24'h000000;
  endfunction
  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  // One pixel cycle; any write/clear set up by the caller is applied to the model after
  // the expectations, so a same-cycle read sees the old cell contents.
  task automatic px(input int xx, input int yy, input bit von = 1);
    x = 10'(xx);
    y = 10'(yy);
    video_on = von;
    if (xx == 0 && yy == 0) nt++;
    qp.push_back('{cyc + 3, {8'b0, exp_rgb(xx, yy, von)}});
    if (xx / 8 < COLS && yy / 8 < ROWS)
      qc.push_back('{cyc + 1, {20'b0, 4'(yy % 8), mdl[(yy / 8) * COLS + xx / 8]}});
    if (clear_req && idle) begin
      foreach (mdl[i]) mdl[i] = 8'h20;
      idle = 0;
    end else if (wr_en && idle && int'(wr_col) < COLS && int'(wr_row) < ROWS)
      mdl[int'(wr_row) * COLS + int'(wr_col)] = wr_char;
    @(posedge clk); #1;
    wr_en = 0;
    clear_req = 0;
    x = 10'd700;
    y = 10'd500;
    video_on = 0;
  endtask
  task automatic wait_clear(input string tag);
    int n = 0;
    while (!wr_ready && n < 6000) begin @(posedge clk); #1; n++; end
    chk(tag, n, 4800);
    idle = 1;
    foreach (mdl[i]) mdl[i] = 8'h20;
  endtask
  task automatic do_reset();
    rst = 1;
    idle = 0;
    nt = 0;
    idle_cycles(2);
  endtask
  initial begin
    #1;
    do_reset();
    chk("rst_rgb", {8'b0, r, g, b}, 0);
    chk("rst_ready", wr_ready, 0);
    chk("rst_glyph_char", glyph_char, 0);
    chk("rst_glyph_row", glyph_row, 0);
    rst = 0;
    idle_cycles(100);
    chk("sweep_busy", wr_ready, 0);
    rst = 1;
    idle_cycles(1);
    chk("rst_mid_ready", wr_ready, 0);
    rst = 0;
    wait_clear("clear_after_rst");
    for (int rr = 0; rr < ROWS; rr++)
      for (int c = 0; c < COLS; c++) px(c * 8 + c % 8, rr * 8 + rr % 8);
    idle_cycles(4);
    wr_en = 1; wr_col = 2; wr_row = 3; wr_char = 8'h41;
    px(700, 500, 0);
    for (int yy = 24; yy < 32; yy++)
      for (int xx = 16; xx < 25; xx++) px(xx, yy);
    wr_en = 1; wr_col = 80; wr_row = 2; wr_char = 8'h5A;
    px(700, 500, 0);
    wr_en = 1; wr_col = 3; wr_row = 60; wr_char = 8'h5A;
    px(700, 500, 0);
    px(1, 24);
    px(24, 25);
    px(1, 472);
    cursor_en = 1; cur_col = 2; cur_row = 3;
    for (int xx = 16; xx < 24; xx++) px(xx, 24, 0);
    for (int xx = 640; xx < 648; xx++) px(xx, 24, 1);
    px(18, 24, 1);
    cur_col = 80;
    px(640, 24, 1);
    cursor_en = 0;
    wr_en = 1; wr_col = 4; wr_row = 4; wr_char = 8'h41;
    px(32, 32);
    px(33, 32);
    px(34, 33);
    idle_cycles(4);
    clear_req = 1; wr_en = 1; wr_col = 5; wr_row = 5; wr_char = 8'h42;
    px(700, 500, 0);
    chk("clear_ready_low", wr_ready, 0);
    wr_en = 1; wr_col = 6; wr_row = 6; wr_char = 8'h43;
    px(700, 500, 0);
    idle_cycles(100);
    clear_req = 1;
    px(700, 500, 0);
    wait_clear("clear_restart");
    px(17, 26); px(33, 34); px(41, 42); px(49, 50); px(1, 24);
    idle_cycles(4);
    do_reset();
    rst = 0;
    wait_clear("clear_second_rst");
    cursor_en = 1; cur_col = 0; cur_row = 0;
    for (int f = 0; f < 6; f++) begin
      px(1, 0); px(2, 3); px(7, 7); px(8, 0); px(12, 5);
      idle_cycles(3);
      px(0, 0);
      idle_cycles(3);
    end
    cursor_en = 0;
    idle_cycles(6);
    chk("queues_drained", qc.size() + qp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/text_overlay_gen.md
Name: text_overlay_gen

Overview:
Parametrised text-mode video generator for the VGA pipeline. Holds a writable character buffer of COLS x ROWS cells, maps each incoming pixel coordinate to a cell and glyph bit, and drives 24-bit RGB with fixed pipeline latency. Adds a cursor with frame-based blink and a clear sweep. Sits between the VGA timing controller (x, y, video_on) and the DAC/RGB output; the glyph ROM is external.

Parameters:
CHAR_W, 8, glyph width in pixels (power of two, 4..8)
CHAR_H, 8, glyph height in pixels (power of two, 4..16)
COLS, 80, text columns
ROWS, 60, text rows
FG_COLOR, 24'hFFFFFF, foreground RGB {r,g,b}
BG_COLOR, 24'h000000, background RGB
BLINK_FRAMES, 30, frames per cursor blink half-period (>=1)
CLEAR_CHAR, 8'h20, code written by the clear sweep

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous active-high reset
x  in  10  current pixel column from timing controller
y  in  10  current pixel row from timing controller
video_on  in  1  active-area flag, aligned with x/y
wr_en  in  1  character write request
wr_col  in  7  target column
wr_row  in  6  target row
wr_char  in  8  character code
wr_ready  out  1  high when writes are accepted
clear_req  in  1  one-cycle pulse: start clear sweep
cursor_en  in  1  enable cursor display
cur_col  in  7  cursor column
cur_row  in  6  cursor row
glyph_char  out  8  character code to glyph ROM
glyph_row  out  4  glyph line index (y mod CHAR_H)
glyph_bits  in  8  glyph line returned 1 cycle after glyph_char/glyph_row
r, g, b  out  8 each  pixel colour

Behaviour:
- One clock (clk); reset synchronous, active-high (rst). All state updates on the rising edge of clk.
- Reset: r/g/b = 0; wr_ready = 0; glyph_char = 0; glyph_row = 0; pipeline valid bits cleared; blink counter = 0; blink phase = 1 (visible). Buffer contents are not reset directly; the FSM enters CLEAR on the cycle after rst deasserts.
- Clear FSM, states IDLE and CLEAR. CLEAR writes CLEAR_CHAR to addresses 0..COLS*ROWS-1, one per cycle, then returns to IDLE; wr_ready = 0 in CLEAR, 1 in IDLE. clear_req in IDLE -> CLEAR from address 0. clear_req in CLEAR restarts at address 0. rst mid-sweep aborts the sweep; a new sweep starts after reset.
- Write port: wr_en && wr_ready && wr_col < COLS && wr_row < ROWS writes wr_char at addr = wr_row*COLS + wr_col. Out-of-range or not-ready writes are dropped silently; there is no queueing. clear_req and wr_en in the same IDLE cycle: clear wins and the write is dropped.
- Buffer: dual-port, synchronous read. A read and a write to the same address in the same cycle return the old data.
- Pixel pipeline (latency 3 from x/y/video_on to r/g/b):
  - S0: col = x / CHAR_W; row = y / CHAR_H; fx = x mod CHAR_W; fy = y mod CHAR_H. in_area = video_on && col < COLS && row < ROWS. is_cur = cursor_en && col == cur_col && row == cur_row. Issue buffer read.
  - S1: glyph_char <= buffer data; glyph_row <= fy. Carry fx, in_area and is_cur.
  - S2: pix = glyph_bits[CHAR_W-1-fx], so the MSB is the leftmost pixel. pix ^= (is_cur && blink_phase).
  - Output register: {r,g,b} = in_area ? (pix ? FG_COLOR : BG_COLOR) : 24'h000000.
- Blink: a frame tick fires when x == 0 && y == 0, sampled in S0, once per frame. The counter increments on each tick. When it reaches BLINK_FRAMES-1 and another tick arrives, the counter wraps to 0 and blink_phase toggles.
- The pipeline keeps running during CLEAR; pixels show partially cleared contents.
- Widths: addr = ceil(log2(COLS*ROWS)) bits; multiply/divide by powers of two are shifts; row*COLS uses a constant multiply.

Test Plan:
- Reset, then wait COLS*ROWS+2 cycles -> wr_ready rises exactly after 4800 cycles; every cell reads 8'h20. rst pulse mid-sweep restarts the count.
- Write 8'h41 at (col 2, row 3); drive x=16..23, y=24..31 with a model ROM returning glyph 'A' -> r/g/b show FF/00 per glyph bits 3 cycles after each x/y; x=24 shows the next cell (space, BG).
- wr_col=80 or wr_row=60 with wr_en -> no buffer change. wr_en during CLEAR -> dropped. clear_req with wr_en in the same cycle -> buffer all 8'h20.
- video_on=0, or x>=640 -> r/g/b = 0 after 3 cycles, regardless of buffer or cursor.
- cursor_en=1 at (0,0), BLINK_FRAMES=2, pulse x=y=0 as frame ticks -> cell 0 inverted for frames 0-1, normal for 2-3, inverted for 4-5. Other cells unaffected.
- Same-cycle write and pixel read of one cell -> the old character is displayed that cycle; the new character is displayed on the next access.
